dco_fll_ctrl: RTL and testbench
===============================

DCO_FLL_CTRL -- requirements
Module: dco_fll_ctrl

Interface
REQ-001 Parameter CNT_W, default 12: width of edge counter and target.
REQ-002 Parameter WINDOW_CYCLES, default 1024: clk cycles per measurement window.
REQ-003 Parameter SETTLE_CYCLES, default 16: clk cycles waited after each dco_code change before measuring.
REQ-004 Parameter TOL, default 2: max |meas_count - target| for lock.
REQ-005 clk  input  1: reference clock; all state on rising edge.
REQ-006 reset  input  1: asynchronous, active-high reset.
REQ-007 start  input  1: one-cycle request to begin a calibration run.
REQ-008 target_count  input  CNT_W: desired DCO rising edges per window; sampled on accepted start.
REQ-009 dco_out  input  1: oscillator output, asynchronous to clk.
REQ-010 dco_code  output  8: control code driven to the DCO.
REQ-011 busy  output  1: high from accepted start until done.
REQ-012 done  output  1: one-cycle pulse at end of run.
REQ-013 locked  output  1: final count within TOL of target.
REQ-014 meas_count  output  CNT_W: edge count of most recent completed window.

Function
REQ-015 dco_out SHALL pass through a 2-flop synchronizer plus one edge-detect flop; a rising edge is sync2 & ~sync3.
REQ-016 Edge counter SHALL clear on entry to MEASURE, increment per detected edge only in MEASURE, saturate at 2^CNT_W-1.
REQ-017 FSM states SHALL be IDLE, SETTLE, MEASURE, DECIDE, FSETTLE, FMEASURE, FINISH.
REQ-018 IDLE: start=1 -> latch target_count, bit index=7, dco_code = previous code with all bits cleared and bit 7 set (8'h80), busy=1, locked=0, go SETTLE.
REQ-019 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then MEASURE.
REQ-020 MEASURE SHALL last exactly WINDOW_CYCLES cycles, then DECIDE; meas_count updates with the final count on exit.
REQ-021 DECIDE (1 cycle): if count > target clear trial bit, else keep; if index>0, set bit index-1, decrement index, go SETTLE; if index=0 go FSETTLE.
REQ-022 FSETTLE/FMEASURE SHALL repeat SETTLE/MEASURE timing on the final code, without changing dco_code.
REQ-023 FINISH (1 cycle): locked = (|count - target| <= TOL) using CNT_W+1-bit unsigned difference; done=1; busy=0; return IDLE.
REQ-024 Run latency from start to done SHALL be 9*(SETTLE_CYCLES+WINDOW_CYCLES) + 9 cycles (8 DECIDE, 1 FINISH) plus the 1-cycle IDLE acceptance.
REQ-025 start while busy SHALL be ignored; run continues unaffected.
REQ-026 In IDLE, dco_code, locked, meas_count SHALL hold last run's values.
REQ-027 Result SHALL be the largest code whose measured count <= target (monotonic DCO assumed); target above max achievable -> 8'hFF; target below code-0 count -> 8'h00.
REQ-028 Input dco_out frequency SHALL be <= clk/4 for correct counting; faster inputs undercount (not flagged).

Reset
REQ-029 reset=1 SHALL immediately force IDLE, dco_code=8'h00, busy=0, done=0, locked=0, meas_count=0, counters and synchronizer flops=0.
REQ-030 reset asserted mid-run SHALL abort the run with no done pulse; next start after release begins a fresh run.

Verification
REQ-031 Behavioral DCO model yielding count=code per 1024-cycle window; target=100 -> dco_code=100, meas_count=100, locked=1, done pulse at REQ-024 latency.
REQ-032 Same model, target=0 -> dco_code=8'h00, meas_count=0, locked=1; target=300 -> dco_code=8'hFF, meas_count=255, locked=0.
REQ-033 dco_out tied low, target=50 -> dco_code=8'hFF, meas_count=0, locked=0.
REQ-034 start pulsed again during run with target=10 -> ignored; result matches first target, exactly one done pulse.
REQ-035 reset pulsed during 4th SETTLE -> all outputs at REQ-029 values within same cycle, no done; subsequent start with target=100 completes normally with dco_code=100.

Source files
------------

// File: rtl/dco_fll_ctrl.sv
// Frequency-locked loop controller: binary-searches an 8-bit DCO code so the
// DCO edge count per reference window is the largest value not above target.
module dco_fll_ctrl #(
    parameter int CNT_W         = 12,
    parameter int WINDOW_CYCLES = 1024,
    parameter int SETTLE_CYCLES = 16,
    parameter int TOL           = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] target_count,
    input  logic             dco_out,
    output logic [7:0]       dco_code,
    output logic             busy,
    output logic             done,
    output logic             locked,
    output logic [CNT_W-1:0] meas_count
);

    localparam int MAXC = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
    localparam int TW   = $clog2(MAXC) + 1;
    localparam logic [TW-1:0] SET_LAST = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] WIN_LAST = TW'(WINDOW_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, SETTLE, MEASURE, DECIDE, FSETTLE, FMEASURE, FINISH
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [TW-1:0]     timer;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_inc;
    logic [CNT_W-1:0]  target;
    logic [2:0]        idx;
    logic [7:0]        trial;
    logic              sync1, sync2, sync3;
    logic              rise;
    logic              measuring;
    logic              leaving;
    logic [CNT_W:0]    diff;
    logic [CNT_W:0]    mag;
    logic              within_tol;

    assign rise      = sync2 & ~sync3;
    assign measuring = (state == MEASURE) || (state == FMEASURE);
    assign leaving   = (state_n != state);
    assign count_inc = (rise && (count != '1)) ? count + CNT_W'(1) : count;

    assign diff       = {1'b0, count_inc} - {1'b0, target};
    assign mag        = diff[CNT_W] ? -diff : diff;
    assign within_tol = (mag <= (CNT_W+1)'(TOL));

    assign busy = (state != IDLE) && (state != FINISH);
    assign done = (state == FINISH);

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:     if (start) state_n = SETTLE;
            SETTLE:   if (timer == SET_LAST) state_n = MEASURE;
            MEASURE:  if (timer == WIN_LAST) state_n = DECIDE;
            DECIDE:   state_n = (idx == 3'd0) ? FSETTLE : SETTLE;
            FSETTLE:  if (timer == SET_LAST) state_n = FMEASURE;
            FMEASURE: if (timer == WIN_LAST) state_n = FINISH;
            FINISH:   state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    // Trial bit is dropped when the DCO ran too fast; next lower bit is tried.
    always_comb begin
        trial = dco_code;
        if (meas_count > target) trial[idx] = 1'b0;
        if (idx != 3'd0) trial[idx - 3'd1] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= dco_out;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer <= '0;
        end else if (leaving || state == IDLE) begin
            timer <= '0;
        end else begin
            timer <= timer + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count      <= '0;
            meas_count <= '0;
        end else begin
            if (leaving && (state_n == MEASURE || state_n == FMEASURE)) begin
                count <= '0;
            end else if (measuring) begin
                count <= count_inc;
            end
            if (measuring && leaving) begin
                meas_count <= count_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dco_code <= 8'h00;
            idx      <= 3'd0;
            target   <= '0;
            locked   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        dco_code <= 8'h80;
                        idx      <= 3'd7;
                        target   <= target_count;
                        locked   <= 1'b0;
                    end
                end
                DECIDE: begin
                    dco_code <= trial;
                    if (idx != 3'd0) idx <= idx - 3'd1;
                end
                FMEASURE: begin
                    if (leaving) locked <= within_tol;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dco_fll_ctrl.sv
// Bench for dco_fll_ctrl: a phase-accumulator DCO yields exactly dco_code
// rising edges per 1024 clk cycles; results checked against a target model.
module tb_dco_fll_ctrl;

    localparam int S   = 16;
    localparam int W   = 1024;
    localparam int LAT = 9 * (S + W) + 9;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [11:0] target_count = '0;
    logic        dco_out;
    logic [7:0]  dco_code;
    logic        busy;
    logic        done;
    logic        locked;
    logic [11:0] meas_count;

    logic [9:0]  ph = '0;
    logic        dco_en = 1'b1;
    int          done_cnt = 0;
    int          n_cmp = 0;
    int          n_fail = 0;

    dco_fll_ctrl #(
        .CNT_W(12), .WINDOW_CYCLES(W), .SETTLE_CYCLES(S), .TOL(2)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .target_count(target_count), .dco_out(dco_out),
        .dco_code(dco_code), .busy(busy), .done(done),
        .locked(locked), .meas_count(meas_count)
    );

    always #5 clk = ~clk;

    // Phase wraps dco_code times per 1024 cycles, so any full window holds
    // exactly dco_code rising edges.
    always @(negedge clk) ph <= ph + {2'b00, dco_code};
    assign dco_out = dco_en & ph[9];

    always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_meas(input int tgt, input bit en);
        if (!en) return 0;
        return (tgt > 255) ? 255 : tgt;
    endfunction

    function automatic int exp_code(input int tgt, input bit en);
        if (!en) return 255;
        return (tgt > 255) ? 255 : tgt;
    endfunction

    function automatic int exp_lock(input int tgt, input bit en);
        int d;
        d = exp_meas(tgt, en) - tgt;
        if (d < 0) d = -d;
        return (d <= 2) ? 1 : 0;
    endfunction

    task automatic run(input int tgt, input bit again, input string nm);
        int lat;
        int dc0;
        logic [7:0] c;
        dc0 = done_cnt;
        @(posedge clk); #1;
        target_count = tgt[11:0];
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < LAT + 100) begin
            @(posedge clk); #1;
            lat++;
            start = again && (lat == 600);
            if (again && lat == 600) target_count = 12'd10;
            if (lat == 100) chk({nm, "_busy_mid"}, busy, 1);
        end
        chk({nm, "_latency"}, lat, LAT);
        chk({nm, "_busy_at_done"}, busy, 0);
        chk({nm, "_code"}, dco_code, exp_code(tgt, dco_en));
        chk({nm, "_meas"}, meas_count, exp_meas(tgt, dco_en));
        chk({nm, "_locked"}, locked, exp_lock(tgt, dco_en));
        @(posedge clk); #1;
        chk({nm, "_done_pulse_end"}, done, 0);
        c = dco_code;
        repeat (20) @(posedge clk);
        #1;
        chk({nm, "_idle_hold_code"}, dco_code, exp_code(tgt, dco_en));
        chk({nm, "_idle_hold_meas"}, meas_count, exp_meas(tgt, dco_en));
        chk({nm, "_done_count"}, done_cnt - dc0, 1);
        if (c !== dco_code) chk({nm, "_code_stable"}, dco_code, c);
    endtask

    initial begin
        int t;
        int dc0;
        #3;
        chk("rst_code", dco_code, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_locked", locked, 0);
        chk("rst_meas", meas_count, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        run(100, 1'b0, "t100");
        run(0, 1'b0, "t0");
        run(300, 1'b0, "t300");

        dco_en = 1'b0;
        run(50, 1'b0, "tied_low");
        dco_en = 1'b1;

        t = $urandom_range(20, 250);
        run(t, 1'b1, "restart_ignored");

        // Abort in the 4th SETTLE: trials 0x80, 0x40, 0x60 give code 0x70.
        dc0 = done_cnt;
        @(posedge clk); #1;
        target_count = 12'd100;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3 * (S + W) + 3 + 5) @(posedge clk);
        #1;
        chk("pre_abort_busy", busy, 1);
        chk("pre_abort_code", dco_code, 8'h70);
        reset = 1'b1;
        #1;
        chk("abort_code", dco_code, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_locked", locked, 0);
        chk("abort_meas", meas_count, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt - dc0, 0);
        chk("abort_idle", busy, 0);
        run(100, 1'b0, "after_abort");

        t = $urandom_range(0, 320);
        run(t, 1'b0, "random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
